// File: rtl/leaderboard_tracker.sv
// Leaderboard tracker: keeps per-player best (or cumulative) scores in an external
// RAM and maintains the overall leader record.
//
// state  | meaning
// INIT   | write 0 to every player slot, one per cycle
// IDLE   | ready for a request or a clear
// CHECK  | classify request: guest, bad id or registered
// FETCH  | issue the RAM read
// RDWAIT | wait out the remaining RAM latency
// CATCH  | capture the stored score
// UPDATE | write back if improved, update the leader record
// DONE   | one-cycle result pulse
module leaderboard_tracker #(
  parameter int NUM_PLAYERS = 8,
  parameter int SCORE_W     = 7,
  parameter int ADDR_W      = 5,
  parameter int RAM_LAT     = 2,
  parameter int MODE        = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score,
  input  logic [4:0]         player_id,
  input  logic               is_guest,
  input  logic               clear_req,
  input  logic [SCORE_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [SCORE_W-1:0] ram_wdata,
  output logic               ram_we,
  output logic               ram_re,
  output logic               ready,
  output logic               valid,
  output logic               err,
  output logic               personal_best,
  output logic               global_best,
  output logic [4:0]         global_id,
  output logic [SCORE_W-1:0] global_score,
  output logic               global_vld
);

  typedef enum logic [2:0] {INIT, IDLE, CHECK, FETCH, RDWAIT, CATCH, UPDATE, DONE} state_t;

  state_t             state, state_n;
  logic               run;
  logic [4:0]         init_cnt;
  logic [1:0]         wait_cnt;
  logic [SCORE_W-1:0] score_q, stored_q, gscore_q;
  logic [4:0]         pid_q, gid_q;
  logic               guest_q, pb_q, gb_q, err_q, gvld_q;

  logic               out_of_range;
  logic [SCORE_W:0]   sum;
  logic [SCORE_W-1:0] new_score;
  logic               improved, take_lead;
  logic [4:0]         gid_after;

  assign out_of_range = {27'd0, pid_q} >= 32'(NUM_PLAYERS);
  assign sum          = {1'b0, stored_q} + {1'b0, score_q};

  always_comb begin
    new_score = score_q;
    if (MODE == 1) new_score = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];
  end

  assign improved  = new_score > stored_q;
  assign take_lead = improved && (!gvld_q || new_score > gscore_q);
  assign gid_after = take_lead ? pid_q : gid_q;

  // Release is captured by one flop so INIT begins on the first edge after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  always_comb begin
    state_n   = state;
    ready     = 1'b0;
    valid     = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state)
      INIT: if (run) begin
        ram_we   = 1'b1;
        ram_addr = ADDR_W'(init_cnt);
        if (init_cnt == 5'(NUM_PLAYERS - 1)) state_n = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (clear_req)      state_n = INIT;
        else if (score_req) state_n = CHECK;
      end
      CHECK:  state_n = (guest_q || out_of_range) ? DONE : FETCH;
      FETCH: begin
        ram_re   = 1'b1;
        ram_addr = ADDR_W'(pid_q);
        state_n  = (RAM_LAT == 1) ? CATCH : RDWAIT;
      end
      RDWAIT: if (wait_cnt == 2'd0) state_n = CATCH;
      CATCH:  state_n = UPDATE;
      UPDATE: begin
        ram_we    = improved;
        ram_addr  = ADDR_W'(pid_q);
        ram_wdata = new_score;
        state_n   = DONE;
      end
      DONE: begin
        valid   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      init_cnt <= '0;
      wait_cnt <= '0;
      score_q  <= '0;
      stored_q <= '0;
      pid_q    <= '0;
      guest_q  <= 1'b0;
      pb_q     <= 1'b0;
      gb_q     <= 1'b0;
      err_q    <= 1'b0;
      gid_q    <= '0;
      gscore_q <= '0;
      gvld_q   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        INIT: if (run) init_cnt <= init_cnt + 5'd1;
        IDLE: begin
          init_cnt <= '0;
          if (clear_req) begin
            gvld_q   <= 1'b0;
            gid_q    <= '0;
            gscore_q <= '0;
          end else if (score_req) begin
            score_q <= score;
            pid_q   <= player_id;
            guest_q <= is_guest;
            pb_q    <= 1'b0;
            gb_q    <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        CHECK: begin
          if (guest_q)           pb_q  <= !gvld_q || (score_q > gscore_q);
          else if (out_of_range) err_q <= 1'b1;
        end
        FETCH:  wait_cnt <= 2'(RAM_LAT - 2);
        RDWAIT: wait_cnt <= wait_cnt - 2'd1;
        CATCH:  stored_q <= ram_rdata;
        UPDATE: begin
          pb_q <= improved;
          gb_q <= (pid_q == gid_after) && (gvld_q || take_lead);
          if (take_lead) begin
            gid_q    <= pid_q;
            gscore_q <= new_score;
            gvld_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign err           = err_q;
  assign personal_best = pb_q;
  assign global_best   = gb_q;
  assign global_id     = gid_q;
  assign global_score  = gscore_q;
  assign global_vld    = gvld_q;

endmodule

// File: tb/tb_leaderboard_tracker.sv
// Directed bench: a best-score instance and a cumulative instance share stimulus,
// each with its own two-cycle-latency RAM model.
module tb_leaderboard_tracker;

  logic       clk = 1'b0;
  logic       rst, score_req, is_guest, clear_req;
  logic [6:0] score;
  logic [4:0] player_id;

  logic [6:0] rdata0, wdata0, gs0, rdata1, wdata1, gs1;
  logic [4:0] addr0, gid0, addr1, gid1;
  logic       we0, re0, ready0, valid0, err0, pb0, gb0, gvld0;
  logic       we1, re1, ready1, valid1, err1, pb1, gb1, gvld1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  leaderboard_tracker #(.NUM_PLAYERS(8), .SCORE_W(7), .ADDR_W(5), .RAM_LAT(2), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .score_req(score_req), .score(score), .player_id(player_id),
    .is_guest(is_guest), .clear_req(clear_req), .ram_rdata(rdata0), .ram_addr(addr0),
    .ram_wdata(wdata0), .ram_we(we0), .ram_re(re0), .ready(ready0), .valid(valid0),
    .err(err0), .personal_best(pb0), .global_best(gb0), .global_id(gid0),
    .global_score(gs0), .global_vld(gvld0));

  leaderboard_tracker #(.NUM_PLAYERS(8), .SCORE_W(7), .ADDR_W(5), .RAM_LAT(2), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .score_req(score_req), .score(score), .player_id(player_id),
    .is_guest(is_guest), .clear_req(clear_req), .ram_rdata(rdata1), .ram_addr(addr1),
    .ram_wdata(wdata1), .ram_we(we1), .ram_re(re1), .ready(ready1), .valid(valid1),
    .err(err1), .personal_best(pb1), .global_best(gb1), .global_id(gid1),
    .global_score(gs1), .global_vld(gvld1));

  // RAM models: read data is only meaningful in the exact cycle two edges after ram_re.
  logic [6:0] mem0 [32];
  logic [6:0] mem1 [32];
  logic [6:0] pd0 [2];
  logic [6:0] pd1 [2];
  logic [1:0] pv0 = 2'b00;
  logic [1:0] pv1 = 2'b00;

  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wdata0;
    if (we1) mem1[addr1] <= wdata1;
    pv0    <= {pv0[0], re0};
    pv1    <= {pv1[0], re1};
    pd0[0] <= mem0[addr0];
    pd0[1] <= pd0[0];
    pd1[0] <= mem1[addr1];
    pd1[1] <= pd1[0];
  end

  assign rdata0 = pv0[1] ? pd0[1] : 7'h55;
  assign rdata1 = pv1[1] ? pd1[1] : 7'h55;

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expects to be entered in the first INIT write cycle; leaves in the first IDLE cycle.
  task automatic init_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (!(we0 && addr0 == 5'(i) && wdata0 == 7'd0 && !ready0 && !valid0 && !re0)) bad++;
      @(posedge clk); #1;
    end
    chk({tag, ".init_writes_bad"}, bad, 0);
    chk({tag, ".ready0_after_init"}, int'(ready0), 1);
    chk({tag, ".ready1_after_init"}, int'(ready1), 1);
  endtask

  task automatic submit(input string tag, input int d, input int pid, input int sc,
                        input bit guest, input int lat, input int e_pb, input int e_gb,
                        input int e_err, input int e_gid, input int e_gs, input int re_n);
    int vcyc = 0, vcnt = 0, recnt = 0, recyc = 0, readdr = 0, clash = 0;
    int s_pb = 0, s_gb = 0, s_err = 0;
    chk({tag, ".ready"}, int'(d != 0 ? ready1 : ready0), 1);
    score_req = 1'b1;
    score     = 7'(sc);
    player_id = 5'(pid);
    is_guest  = guest;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      score_req = 1'b0;
      is_guest  = 1'b0;
      if (d != 0 ? valid1 : valid0) begin
        vcnt++;
        vcyc  = k;
        s_pb  = int'(d != 0 ? pb1 : pb0);
        s_gb  = int'(d != 0 ? gb1 : gb0);
        s_err = int'(d != 0 ? err1 : err0);
      end
      if (d != 0 ? re1 : re0) begin
        recnt++;
        recyc  = k;
        readdr = int'(d != 0 ? addr1 : addr0);
      end
      if (d != 0 ? (we1 && re1) : (we0 && re0)) clash++;
    end
    chk({tag, ".valid_latency"}, vcyc, lat);
    chk({tag, ".valid_pulses"}, vcnt, 1);
    chk({tag, ".ram_re_pulses"}, recnt, re_n);
    if (re_n > 0) begin
      chk({tag, ".ram_re_cycle"}, recyc, 2);
      chk({tag, ".ram_re_addr"}, readdr, pid);
    end
    chk({tag, ".we_re_clash"}, clash, 0);
    chk({tag, ".personal_best"}, s_pb, e_pb);
    chk({tag, ".global_best"}, s_gb, e_gb);
    chk({tag, ".err"}, s_err, e_err);
    chk({tag, ".global_id"}, int'(d != 0 ? gid1 : gid0), e_gid);
    chk({tag, ".global_score"}, int'(d != 0 ? gs1 : gs0), e_gs);
    chk({tag, ".global_vld"}, int'(d != 0 ? gvld1 : gvld0), 1);
    chk({tag, ".pb_held"}, int'(d != 0 ? pb1 : pb0), e_pb);
    chk({tag, ".err_held"}, int'(d != 0 ? err1 : err0), e_err);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    rst = 1'b1; score_req = 1'b0; is_guest = 1'b0; clear_req = 1'b0;
    score = '0; player_id = '0;
    #2 rst = 1'b0;
    #1;
    chk("rst.ready", int'(ready0), 0);
    chk("rst.valid", int'(valid0), 0);
    chk("rst.global_vld", int'(gvld0), 0);
    chk("rst.ram_addr", int'(addr0), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ram_we_held_low", int'(we0), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    init_check("boot");

    submit("p3_50", 0, 3, 50, 1'b0, 6, 1, 1, 0, 3, 50, 1);
    chk("p3_50.mem", int'(mem0[3]), 50);
    submit("p3_40", 0, 3, 40, 1'b0, 6, 0, 1, 0, 3, 50, 1);
    chk("p3_40.mem", int'(mem0[3]), 50);
    submit("p3_60", 0, 3, 60, 1'b0, 6, 1, 1, 0, 3, 60, 1);
    submit("p1_tie60", 0, 1, 60, 1'b0, 6, 1, 0, 0, 3, 60, 1);
    chk("p1_tie60.mem", int'(mem0[1]), 60);
    submit("guest61", 0, 0, 61, 1'b1, 2, 1, 0, 0, 3, 60, 0);
    submit("guest59", 0, 0, 59, 1'b1, 2, 0, 0, 0, 3, 60, 0);
    submit("bad_id9", 0, 9, 20, 1'b0, 2, 0, 0, 1, 3, 60, 0);

    clear_req = 1'b1; score_req = 1'b1; player_id = 5'd3; score = 7'd10;
    @(posedge clk); #1;
    clear_req = 1'b0; score_req = 1'b0;
    chk("clr.global_vld0", int'(gvld0), 0);
    chk("clr.global_vld1", int'(gvld1), 0);
    chk("clr.global_id0", int'(gid0), 0);
    chk("clr.global_score0", int'(gs0), 0);
    init_check("clear");
    chk("clr.mem3", int'(mem0[3]), 0);

    submit("m1_100a", 1, 2, 100, 1'b0, 6, 1, 1, 0, 2, 100, 1);
    chk("m1_100a.mem", int'(mem1[2]), 100);
    submit("m1_100b", 1, 2, 100, 1'b0, 6, 1, 1, 0, 2, 127, 1);
    chk("m1_100b.mem", int'(mem1[2]), 127);
    submit("m1_5", 1, 2, 5, 1'b0, 6, 0, 1, 0, 2, 127, 1);
    chk("m1_5.mem", int'(mem1[2]), 127);

    score_req = 1'b1; player_id = 5'd4; score = 7'd30;
    @(posedge clk); #1;
    score_req = 1'b0;
    @(posedge clk); #1;
    chk("rd_rst.fetch_re", int'(re0), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rd_rst.ready", int'(ready0), 0);
    chk("rd_rst.ram_re", int'(re0), 0);
    chk("rd_rst.ram_we", int'(we0), 0);
    chk("rd_rst.global_vld0", int'(gvld0), 0);
    chk("rd_rst.global_score1", int'(gs1), 0);
    nv = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (valid0) nv++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    if (valid0) nv++;
    init_check("rd_rst");
    chk("rd_rst.no_valid", nv, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
